// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
// i2s_tx: mono 16-bit sample to Philips I2S serialiser with a single-entry
// holding register, a frame register and overrun/underrun pulse flags.
module i2s_tx #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clkEn,
  input  logic [15:0] iIn,
  output logic        oBclk,
  output logic        oLrclk,
  output logic        oSdata,
  output logic        oUnderrun,
  output logic        oOverrun
);

  localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [4:0]       slot;
  logic [4:0]       slot_nxt;
  logic [15:0]      hold;
  logic [15:0]      frame;
  logic [15:0]      frame_nxt;
  logic             valid;
  logic             wrap;
  logic             slot_edge;
  logic             load;
  logic             sdata_nxt;

  // Slot-edge detection, frame load selection and next serial bit.
  always_comb begin
    wrap      = (div == DIV_LAST);
    slot_edge = wrap && oBclk;
    slot_nxt  = slot + 5'd1;
    load      = slot_edge && (slot == 5'd0);
    frame_nxt = frame;
    if (load) begin
      if (clkEn) begin
        frame_nxt = iIn;
      end else if (valid) begin
        frame_nxt = hold;
      end
    end
    // Slots 1..16 send bit 16-n and slots 17..31/0 send bit 32-n; both equal
    // bit (-n mod 16), and slot 0 (no load) picks the previous word's LSB.
    sdata_nxt = frame_nxt[4'(5'd0 - slot_nxt)];
  end

  // Bit-clock divider: toggle oBclk each time div wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div   <= '0;
      oBclk <= 1'b0;
    end else if (wrap) begin
      div   <= '0;
      oBclk <= ~oBclk;
    end else begin
      div   <= div + DIV_W'(1);
    end
  end

  // Slot counter and registered word-select/data, advanced on falling bclk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot   <= 5'd31;
      oLrclk <= 1'b1;
      oSdata <= 1'b0;
    end else if (slot_edge) begin
      slot   <= slot_nxt;
      oLrclk <= slot_nxt[4];
      oSdata <= sdata_nxt;
    end
  end

  // Holding/frame registers and one-cycle overrun/underrun flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold      <= '0;
      valid     <= 1'b0;
      frame     <= '0;
      oUnderrun <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      oUnderrun <= 1'b0;
      oOverrun  <= 1'b0;
      frame     <= frame_nxt;
      if (load) begin
        valid <= 1'b0;
        if (clkEn) begin
          oOverrun <= valid;
        end else if (!valid) begin
          oUnderrun <= 1'b1;
        end
      end else if (clkEn) begin
        hold     <= iIn;
        valid    <= 1'b1;
        oOverrun <= valid;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
// Self-checking bench for i2s_tx with an arithmetic reference model.
module tb_i2s_tx;

  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clkEn = 1'b0;
  logic [15:0] iIn = '0;
  logic        oBclk, oLrclk, oSdata, oUnderrun, oOverrun;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  i2s_tx #(.BCLK_DIV(D)) dut (
    .clk(clk), .rstn(rstn), .clkEn(clkEn), .iIn(iIn),
    .oBclk(oBclk), .oLrclk(oLrclk), .oSdata(oSdata),
    .oUnderrun(oUnderrun), .oOverrun(oOverrun)
  );

  always #5 clk = ~clk;

  // Reference model: edge e after reset gives bclk phase e/D, slot edges every
  // 2D edges, slot = (e/2D - 1) mod 32, load when entering slot 1.
  int unsigned e;
  int unsigned m_s;
  bit          m_pend, m_sedge, m_ov, m_un, m_lr, m_sd, m_bk;
  logic [15:0] m_pdata, m_frame;
  logic [4:0]  m_slot;
  logic [4:0]  exp_o; // {bclk, lrclk, sdata, underrun, overrun}

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e = 0; m_pend = 0; m_pdata = '0; m_frame = '0;
      m_slot = 5'd31; m_sedge = 0; exp_o = 5'b01000;
    end else begin
      e++;
      m_ov = 0; m_un = 0;
      m_bk = ((e / D) % 2) == 1;
      m_lr = exp_o[3]; m_sd = exp_o[2];
      m_sedge = (e % (2 * D)) == 0;
      if (m_sedge) m_slot = 5'((e / (2 * D) + 31) % 32);
      if (m_sedge && m_slot == 5'd1) begin
        if (clkEn) begin
          m_ov = m_pend; m_frame = iIn; m_pend = 0;
        end else if (m_pend) begin
          m_frame = m_pdata; m_pend = 0;
        end else begin
          m_un = 1;
        end
      end else if (clkEn) begin
        m_ov = m_pend; m_pend = 1; m_pdata = iIn;
      end
      if (m_sedge) begin
        m_s  = m_slot;
        m_lr = (m_s >= 16);
        if (m_s == 0)       m_sd = m_frame[0];
        else if (m_s <= 16) m_sd = m_frame[16 - m_s];
        else                m_sd = m_frame[32 - m_s];
      end
      exp_o = {m_bk, m_lr, m_sd, m_un, m_ov};
    end
  end

  function automatic bit load_next();
    return ((e + 1) % (2 * D) == 0) && (((e + 1) / (2 * D)) % 32 == 2);
  endfunction

  // One clock: present inputs, let the edge pass, return at the falling edge.
  task automatic cyc(input bit en, input logic [15:0] d);
    clkEn = en; iIn = d;
    @(posedge clk);
    @(negedge clk);
    clkEn = 1'b0;
  endtask

  task automatic wait_load();
    for (int k = 0; k < 300 && !load_next(); k++) cyc(1'b0, iIn);
    compared++;
    if (!load_next()) begin
      mismatched++;
      $display("FAIL wait_load timeout e=%0d", e);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; clkEn = 1'b1; iIn = 16'hFFFF;
    repeat (3) @(negedge clk);
    #1;
    compared++;
    if ({oBclk, oLrclk, oSdata, oUnderrun, oOverrun} !== 5'b01000) begin
      mismatched++;
      $display("FAIL reset_hold got=%b want=01000", {oBclk, oLrclk, oSdata, oUnderrun, oOverrun});
    end
    @(negedge clk);
    clkEn = 1'b0; rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 16'h0000);
      compared++;
      if (oBclk !== ((i % 4) == 1 || (i % 4) == 2) || oLrclk !== (i < 3)) begin
        mismatched++;
        $display("FAIL reset_edge%0d bclk=%b lr=%b want bclk=%b lr=%b", i + 1, oBclk, oLrclk,
                 ((i % 4) == 1 || (i % 4) == 2), (i < 3));
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] lw, rw;
    int unsigned un, ov;
    lw = '0; rw = '0; un = 0; ov = 0;
    cyc(1'b1, 16'hA5C3);
    wait_load();
    for (int i = 0; i < 31 * 2 * D + 1; i++) begin
      cyc(1'b0, 16'h0000);
      compared++;
      if ({oBclk, oLrclk, oSdata, oUnderrun, oOverrun} !== exp_o) begin
        mismatched++;
        $display("FAIL single cyc%0d got=%b want=%b", i, {oBclk, oLrclk, oSdata, oUnderrun, oOverrun}, exp_o);
      end
      if (m_sedge && m_slot >= 1 && m_slot <= 16) lw = {lw[14:0], oSdata};
      if (m_sedge && (m_slot >= 17 || m_slot == 0)) rw = {rw[14:0], oSdata};
      if (oUnderrun) un++;
      if (oOverrun) ov++;
    end
    compared++;
    if (lw !== 16'hA5C3 || rw !== 16'hA5C3 || un != 0 || ov != 0) begin
      mismatched++;
      $display("FAIL single_word left=%h right=%h un=%0d ov=%0d want a5c3 a5c3 0 0", lw, rw, un, ov);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] lw;
    int unsigned un, ov;
    lw = '0; un = 0; ov = 0;
    wait_load();
    for (int i = 0; i < 16 * 2 * D; i++) begin
      cyc(1'b0, 16'h0000);
      compared++;
      if ({oBclk, oLrclk, oSdata, oUnderrun, oOverrun} !== exp_o || (i == 0 && oUnderrun !== 1'b1)) begin
        mismatched++;
        $display("FAIL underrun cyc%0d got=%b want=%b", i, {oBclk, oLrclk, oSdata, oUnderrun, oOverrun}, exp_o);
      end
      if (m_sedge && m_slot >= 1 && m_slot <= 16) lw = {lw[14:0], oSdata};
      if (oUnderrun) un++;
      if (oOverrun) ov++;
    end
    compared++;
    if (lw !== 16'hA5C3 || un != 1 || ov != 0) begin
      mismatched++;
      $display("FAIL underrun_word word=%h un=%0d ov=%0d want a5c3 1 0", lw, un, ov);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] lw;
    int unsigned un, ov;
    lw = '0; un = 0; ov = 0;
    cyc(1'b1, 16'h1234);
    compared++;
    if (oOverrun !== 1'b0) begin
      mismatched++; $display("FAIL overrun_first got=%b want=0", oOverrun);
    end
    cyc(1'b0, 16'h0000);
    cyc(1'b1, 16'h8001);
    compared++;
    if (oOverrun !== 1'b1) begin
      mismatched++; $display("FAIL overrun_second got=%b want=1", oOverrun);
    end
    cyc(1'b0, 16'h0000);
    compared++;
    if (oOverrun !== 1'b0) begin
      mismatched++; $display("FAIL overrun_width got=%b want=0", oOverrun);
    end
    wait_load();
    for (int i = 0; i < 16 * 2 * D; i++) begin
      cyc(1'b0, 16'h0000);
      compared++;
      if ({oBclk, oLrclk, oSdata, oUnderrun, oOverrun} !== exp_o) begin
        mismatched++;
        $display("FAIL overrun cyc%0d got=%b want=%b", i, {oBclk, oLrclk, oSdata, oUnderrun, oOverrun}, exp_o);
      end
      if (m_sedge && m_slot >= 1 && m_slot <= 16) lw = {lw[14:0], oSdata};
      if (oUnderrun) un++;
      if (oOverrun) ov++;
    end
    compared++;
    if (lw !== 16'h8001 || un != 0 || ov != 0) begin
      mismatched++;
      $display("FAIL overrun_word word=%h un=%0d ov=%0d want 8001 0 0", lw, un, ov);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] lw;
    int unsigned un, ov;
    for (int pass = 0; pass < 2; pass++) begin
      lw = '0; un = 0; ov = 0;
      if (pass == 1) cyc(1'b1, 16'h0001);
      wait_load();
      for (int i = 0; i < 16 * 2 * D; i++) begin
        cyc(i == 0, 16'h7FFF);
        compared++;
        if ({oBclk, oLrclk, oSdata, oUnderrun, oOverrun} !== exp_o) begin
          mismatched++;
          $display("FAIL bypass%0d cyc%0d got=%b want=%b", pass, i,
                   {oBclk, oLrclk, oSdata, oUnderrun, oOverrun}, exp_o);
        end
        if (m_sedge && m_slot >= 1 && m_slot <= 16) lw = {lw[14:0], oSdata};
        if (oUnderrun) un++;
        if (oOverrun) ov++;
      end
      compared++;
      if (lw !== 16'h7FFF || un != 0 || ov != int'(pass)) begin
        mismatched++;
        $display("FAIL bypass%0d_word word=%h un=%0d ov=%0d want 7fff 0 %0d", pass, lw, un, ov, pass);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] lw;
    int unsigned un, ov;
    lw = '0; un = 0; ov = 0;
    cyc(1'b1, 16'hFFFF);
    wait_load();
    for (int i = 0; i < 9 * 2 * D + 1; i++) cyc(1'b0, 16'h0000);
    compared++;
    if (oSdata !== 1'b1 || oLrclk !== 1'b0) begin
      mismatched++; $display("FAIL mid_pre sd=%b lr=%b want 1 0", oSdata, oLrclk);
    end
    rstn = 1'b0;
    #1;
    compared++;
    if (oSdata !== 1'b0 || oLrclk !== 1'b1 || oBclk !== 1'b0) begin
      mismatched++; $display("FAIL mid_reset sd=%b lr=%b bclk=%b want 0 1 0", oSdata, oLrclk, oBclk);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_load();
    for (int i = 0; i < 16 * 2 * D; i++) begin
      cyc(1'b0, 16'h0000);
      compared++;
      if ({oBclk, oLrclk, oSdata, oUnderrun, oOverrun} !== exp_o) begin
        mismatched++;
        $display("FAIL mid cyc%0d got=%b want=%b", i, {oBclk, oLrclk, oSdata, oUnderrun, oOverrun}, exp_o);
      end
      if (m_sedge && m_slot >= 1 && m_slot <= 16) lw = {lw[14:0], oSdata};
      if (oUnderrun) un++;
      if (oOverrun) ov++;
    end
    compared++;
    if (lw !== 16'h0000 || un != 1 || ov != 0) begin
      mismatched++;
      $display("FAIL mid_word word=%h un=%0d ov=%0d want 0000 1 0", lw, un, ov);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * 64 * D; i++) begin
      cyc($urandom_range(0, 99) < 2, 16'($urandom));
      compared++;
      if ({oBclk, oLrclk, oSdata, oUnderrun, oOverrun} !== exp_o) begin
        mismatched++;
        $display("FAIL random cyc%0d got=%b want=%b", i, {oBclk, oLrclk, oSdata, oUnderrun, oOverrun}, exp_o);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_underrun();
    test_overrun();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serialises the 16-bit signed output of the 15 kHz output low-pass filter into a Philips-format I2S stream for the external audio DAC. The filter output is mono; the same sample is sent on left and right. The block is a single-entry holding register plus a frame register and a bit-clock/slot generator. Holding and frame registers let filter strobes (`clkEn`) and the I2S frame rate be unrelated; overruns and underruns are flagged.

## Interface
- `BCLK_DIV`, default 4: `clk` cycles per half period of `oBclk`. Legal range 2..256.

- `clk`  in  1  system clock; all state on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `clkEn`  in  1  sample strobe, 1-cycle pulse when `iIn` is new (same strobe that advances the filter).
- `iIn`  in  16  signed sample (filter `oOut`), valid when `clkEn`=1.
- `oBclk`  out  1  I2S bit clock, `clk`/(2·`BCLK_DIV`), 50% duty.
- `oLrclk`  out  1  word select: 0 = left slot, 1 = right slot.
- `oSdata`  out  1  serial data, MSB first, changes on `oBclk` falling edge.
- `oUnderrun`  out  1  1-cycle pulse: frame loaded with no new sample (previous repeated).
- `oOverrun`  out  1  1-cycle pulse: an unconsumed sample was overwritten.

## Operation
- Divider counter `div` counts 0..`BCLK_DIV`-1 and wraps. On wrap, `oBclk` toggles.
- A falling toggle (1→0) is a slot edge. Slot counter `slot` (5 bits) advances by 1 mod 32 on each slot edge.
- `oLrclk` and `oSdata` are registered and update on the slot-edge clock.
- During slot n: `oLrclk` = (n ≥ 16).
- `oSdata` during slot n:
  - n=0: bit 0 of the previous frame word.
  - n=1..16: `frame[16-n]`.
  - n=17..31: `frame[32-n]`.
  - The right word's LSB therefore lands in slot 0 of the following frame, giving Philips one-bit delay.
- Holding register `hold` and flag `valid`:
  - `clkEn` writes `iIn` to `hold` and sets `valid`.
  - If `valid` was already 1 and no load occurs that cycle: old sample is lost and `oOverrun` pulses the next cycle.
- Frame load happens on the slot edge entering slot 1:
  - `clkEn`=1 that cycle: `frame` ← `iIn` (bypass) and `valid` ← 0. If `valid` was 1, `oOverrun` pulses.
  - Else if `valid`=1: `frame` ← `hold` and `valid` ← 0.
  - Else: `frame` unchanged and `oUnderrun` pulses.
- Samples are passed bit-exact; no scaling, saturation or dither.

## Timing
- Reset values (asserted asynchronously, held while `rstn`=0):
  - Outputs: `oBclk`=0, `oLrclk`=1, `oSdata`=0, `oUnderrun`=0, `oOverrun`=0.
  - Internal: `div`=0, `slot`=31, `hold`=0, `valid`=0, `frame`=0.
- After `rstn` rises, counting from the first `clk` edge as edge 1:
  - `oBclk` rises at edge `BCLK_DIV` and falls at edge 2·`BCLK_DIV`.
  - Edge 2·`BCLK_DIV` enters slot 0. Edge 4·`BCLK_DIV` enters slot 1; this is the first frame load.
- Frame period: 64·`BCLK_DIV` `clk` cycles.
- Latency:
  - A sample accepted at or before a load edge appears as MSB on `oSdata` from that edge.
  - Worst case, strobe to MSB: one frame period.
- Pulse timing:
  - `oUnderrun`/`oOverrun` assert on the `clk` edge after the triggering condition, for exactly one cycle.
  - At most one of each per cycle; both may pulse together only if an overwrite and a load coincide, which is impossible by construction. They are independent registers.
- Reset mid-frame: all state returns to reset values immediately; the stream restarts as above. The first load after reset underruns unless a sample arrived.
- `clkEn` may arrive in any cycle, including while `rstn` is being released; it is ignored while `rstn`=0.

## Test plan
- Reset, `BCLK_DIV`=2: hold `rstn` low → `oBclk`=0, `oLrclk`=1, `oSdata`=0. Release → `oBclk` rises at edge 2, falls at edge 4, `oLrclk`=0 from edge 4; period 4 `clk`.
- Single strobe `iIn`=16'hA5C3 before first load → slots 1..16 and 17..31 serialise 1010010111000011 MSB first (right LSB in next slot 0 = 1); `oLrclk` 0 for slots 0..15, 1 for 16..31; no pulses.
- No further strobes → next frame repeats 16'hA5C3; `oUnderrun` pulses once, one cycle after the slot-1 edge.
- Strobes 16'h1234 then 16'h8001 within one frame → `oOverrun` one pulse after the second strobe; next frame transmits 16'h8001.
- Strobe 16'h7FFF on exactly the slot-1 load cycle with `valid`=0 → 16'h7FFF sent in that frame, no pulses. Repeat with `valid`=1 (`hold`=16'h0001) → 16'h7FFF sent, `oOverrun` pulses.
- Assert `rstn` low during slot 10 of a 16'hFFFF frame → `oSdata`=0, `oLrclk`=1 immediately. After release, first frame transmits 16'h0000 with `oUnderrun` pulse.
